// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encodings and default width shared by the serial adder files
package serial_add_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam int SERIAL_ADD_W_DEF = 8;
endpackage

// File: rtl/fa.sv
// fa: single-bit full adder, the shared bit-slice of the serial adder
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller stepping one fa LSB-first per clock
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, ps_q, ps_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             fa_s, fa_co, accept, last;

    fa u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last   = cnt_q == CNT_LAST;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == ST_SHIFT) begin
            // widening by one bit keeps the shift-in legal for WIDTH=1
            ps_d    = WIDTH'({fa_s, ps_q} >> 1);
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                sum_d   = ps_d;
                cout_d  = fa_co;
                state_d = ST_DONE;
            end
        end else if (accept) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
    // carry_q on the last SHIFT cycle is the carry into the MSB
    assign ovf_d = (state_q == ST_SHIFT && last) ? (carry_q ^ fa_co) : ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif

    assign busy = state_q == ST_SHIFT;
    assign done = state_q == ST_DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random and directed checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0, n_err = 0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_cout = 1'b0, exp_ovf = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        exp_sum  = t[W-1:0];
        exp_cout = t[W];
        exp_ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, ovf, exp_ovf);
`endif
    endtask

    // issues one op from IDLE/DONE and returns at the negedge inside DONE
    task automatic do_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
        for (int i = 0; i < W; i++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            chk({tag, "_held"}, sum, exp_sum);
            @(negedge clk);
        end
        model(x, y, c);
        chk_result(tag);
        chk({tag, "_notbusy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        do_add("t5a33", 8'h5A, 8'h33, 1'b0);
        do_add("tff01", 8'hFF, 8'h01, 1'b0);
        do_add("tffff", 8'hFF, 8'hFF, 1'b1);

        // start pulse during SHIFT must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (i == 3) begin a = 8'h7F; b = 8'h7F; start = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done) dones++;
            @(negedge clk);
        end
        chk("ign_dones", dones, 1);
        chk("ign_sum", sum, 8'h30);

        // start held across DONE: back-to-back ops
        @(negedge clk);
        a = 8'h05; b = 8'h05; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h02;
        for (int i = 0; i < W; i++) @(negedge clk);
        model(8'h05, 8'h05, 1'b0);
        chk_result("b2b1");
        @(negedge clk);
        start = 1'b0;
        chk("b2b_noidle", busy, 1);
        for (int i = 0; i < W; i++) @(negedge clk);
        model(8'h01, 8'h02, 1'b0);
        chk_result("b2b2");

        // async reset in the 4th SHIFT cycle
        @(negedge clk);
        a = 8'hC3; b = 8'h5D; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("arst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("arst_nodone", dones, 0);
        exp_sum = '0;
        do_add("t1234", 8'h12, 8'h34, 1'b0);

        for (int n = 0; n < 25; n++) do_add("rnd", W'($urandom), W'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
